// File: rtl/gpio_reg_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_reg_array_pkg
// Description : Shared constants, slot index type and address helper for the
//               GPIO register-mirror bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_reg_array_pkg;

    localparam int MAX_REGS    = 20;
    localparam int DATA_W      = 32;
    localparam int ADDR_STRIDE = 4;
    localparam int IDX_W       = 5;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

    typedef logic [IDX_W-1:0] slot_idx_t;

    function automatic logic [DATA_W-1:0] slot_offset(input slot_idx_t idx);
        return DATA_W'(idx) * DATA_W'(ADDR_STRIDE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_reg_scan.sv
`default_nettype none
// ============================================================================
// Module      : gpio_reg_scan
// Description : Slot index counter with stall/wrap handling plus the read
//               capture pipeline. Stall honoured only with
//               GPIO_REG_ARRAY_BUSY_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_reg_scan
    import gpio_reg_array_pkg::*;
#(
    parameter int                  NUM_REGS  = MAX_REGS,
    parameter logic [MAX_REGS-1:0] READ_MASK = '0
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_busy,
    output slot_idx_t o_slot_idx,
    output logic      o_issue,
    output logic      o_cap_valid,
    output slot_idx_t o_cap_idx
);

    slot_idx_t r_idx;
    logic      r_pend_valid;
    slot_idx_t r_pend_idx;
    logic      r_cap_valid;
    slot_idx_t r_cap_idx;
    logic      w_stall;

`ifdef GPIO_REG_ARRAY_BUSY_EN
    assign w_stall = i_busy;
`else
    logic w_unused_busy;
    assign w_unused_busy = i_busy;
    assign w_stall       = 1'b0;
`endif

    // r_pend tracks the read currently on the BRAM bus; r_cap lines up with rddata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_idx    <= '0;
        end else begin
            if (!w_stall) begin
                if (r_idx == slot_idx_t'(NUM_REGS - 1))
                    r_idx <= '0;
                else
                    r_idx <= r_idx + 1'b1;
            end
            r_pend_valid <= !w_stall && READ_MASK[r_idx];
            r_pend_idx   <= r_idx;
            r_cap_valid  <= r_pend_valid;
            r_cap_idx    <= r_pend_idx;
        end
    end

    assign o_slot_idx  = r_idx;
    assign o_issue     = !w_stall;
    assign o_cap_valid = r_cap_valid;
    assign o_cap_idx   = r_cap_idx;

endmodule
`default_nettype wire

// File: rtl/gpio_reg_array_core.sv
`default_nettype none
// ============================================================================
// Module      : gpio_reg_array_core
// Description : Scans up to 20 register slots, mirroring fabric GPIO values
//               into BRAM (input slots) and BRAM words onto out ports (output
//               slots). BRAM_busy stalls only with GPIO_REG_ARRAY_BUSY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_reg_array_core
    import gpio_reg_array_pkg::*;
#(
    parameter int NUM_REGS   = 20,
    parameter int BRAM_WIDTH = 11,
    parameter int WIDTH_00 = 32, parameter int WIDTH_01 = 32, parameter int WIDTH_02 = 32,
    parameter int WIDTH_03 = 32, parameter int WIDTH_04 = 32, parameter int WIDTH_05 = 32,
    parameter int WIDTH_06 = 32, parameter int WIDTH_07 = 32, parameter int WIDTH_08 = 32,
    parameter int WIDTH_09 = 32, parameter int WIDTH_10 = 32, parameter int WIDTH_11 = 32,
    parameter int WIDTH_12 = 32, parameter int WIDTH_13 = 32, parameter int WIDTH_14 = 32,
    parameter int WIDTH_15 = 32, parameter int WIDTH_16 = 32, parameter int WIDTH_17 = 32,
    parameter int WIDTH_18 = 32, parameter int WIDTH_19 = 32,
    parameter int OUT00_INPUT = 0, parameter int OUT01_INPUT = 0, parameter int OUT02_INPUT = 0,
    parameter int OUT03_INPUT = 0, parameter int OUT04_INPUT = 0, parameter int OUT05_INPUT = 0,
    parameter int OUT06_INPUT = 0, parameter int OUT07_INPUT = 0, parameter int OUT08_INPUT = 0,
    parameter int OUT09_INPUT = 0, parameter int OUT10_INPUT = 0, parameter int OUT11_INPUT = 0,
    parameter int OUT12_INPUT = 0, parameter int OUT13_INPUT = 0, parameter int OUT14_INPUT = 0,
    parameter int OUT15_INPUT = 0, parameter int OUT16_INPUT = 0, parameter int OUT17_INPUT = 0,
    parameter int OUT18_INPUT = 0, parameter int OUT19_INPUT = 0
)(
    input  logic                  aclk,
    input  logic                  areset,
    output logic [BRAM_WIDTH-1:0] BRAM_addr,
    output logic [DATA_W-1:0]     BRAM_wrdata,
    input  logic [DATA_W-1:0]     BRAM_rddata,
    output logic                  BRAM_en,
    output logic [3:0]            BRAM_we,
    output logic                  BRAM_clk,
    output logic                  BRAM_rst,
    input  logic                  BRAM_busy,
    input  logic [WIDTH_00-1:0] in00, output logic [WIDTH_00-1:0] out00,
    input  logic [WIDTH_01-1:0] in01, output logic [WIDTH_01-1:0] out01,
    input  logic [WIDTH_02-1:0] in02, output logic [WIDTH_02-1:0] out02,
    input  logic [WIDTH_03-1:0] in03, output logic [WIDTH_03-1:0] out03,
    input  logic [WIDTH_04-1:0] in04, output logic [WIDTH_04-1:0] out04,
    input  logic [WIDTH_05-1:0] in05, output logic [WIDTH_05-1:0] out05,
    input  logic [WIDTH_06-1:0] in06, output logic [WIDTH_06-1:0] out06,
    input  logic [WIDTH_07-1:0] in07, output logic [WIDTH_07-1:0] out07,
    input  logic [WIDTH_08-1:0] in08, output logic [WIDTH_08-1:0] out08,
    input  logic [WIDTH_09-1:0] in09, output logic [WIDTH_09-1:0] out09,
    input  logic [WIDTH_10-1:0] in10, output logic [WIDTH_10-1:0] out10,
    input  logic [WIDTH_11-1:0] in11, output logic [WIDTH_11-1:0] out11,
    input  logic [WIDTH_12-1:0] in12, output logic [WIDTH_12-1:0] out12,
    input  logic [WIDTH_13-1:0] in13, output logic [WIDTH_13-1:0] out13,
    input  logic [WIDTH_14-1:0] in14, output logic [WIDTH_14-1:0] out14,
    input  logic [WIDTH_15-1:0] in15, output logic [WIDTH_15-1:0] out15,
    input  logic [WIDTH_16-1:0] in16, output logic [WIDTH_16-1:0] out16,
    input  logic [WIDTH_17-1:0] in17, output logic [WIDTH_17-1:0] out17,
    input  logic [WIDTH_18-1:0] in18, output logic [WIDTH_18-1:0] out18,
    input  logic [WIDTH_19-1:0] in19, output logic [WIDTH_19-1:0] out19
);

    localparam int c_WIDTH [MAX_REGS] = '{
        WIDTH_00, WIDTH_01, WIDTH_02, WIDTH_03, WIDTH_04, WIDTH_05, WIDTH_06,
        WIDTH_07, WIDTH_08, WIDTH_09, WIDTH_10, WIDTH_11, WIDTH_12, WIDTH_13,
        WIDTH_14, WIDTH_15, WIDTH_16, WIDTH_17, WIDTH_18, WIDTH_19};

    localparam logic [MAX_REGS-1:0] c_IS_WRITE = {
        OUT19_INPUT != 0, OUT18_INPUT != 0, OUT17_INPUT != 0, OUT16_INPUT != 0,
        OUT15_INPUT != 0, OUT14_INPUT != 0, OUT13_INPUT != 0, OUT12_INPUT != 0,
        OUT11_INPUT != 0, OUT10_INPUT != 0, OUT09_INPUT != 0, OUT08_INPUT != 0,
        OUT07_INPUT != 0, OUT06_INPUT != 0, OUT05_INPUT != 0, OUT04_INPUT != 0,
        OUT03_INPUT != 0, OUT02_INPUT != 0, OUT01_INPUT != 0, OUT00_INPUT != 0};

    slot_idx_t             w_idx;
    logic                  w_issue;
    logic                  w_cap_valid;
    slot_idx_t             w_cap_idx;
    logic [DATA_W-1:0]     w_in      [MAX_REGS];
    logic [DATA_W-1:0]     w_wr_word [MAX_REGS];
    logic                  w_unused_rd;
    logic                  r_bram_en;
    logic [3:0]            r_bram_we;
    logic [BRAM_WIDTH-1:0] r_bram_addr;
    logic [DATA_W-1:0]     r_bram_wrdata;

    gpio_reg_scan #(
        .NUM_REGS  (NUM_REGS),
        .READ_MASK (~c_IS_WRITE)
    ) u_scan (
        .clk         (aclk),
        .rst         (areset),
        .i_busy      (BRAM_busy),
        .o_slot_idx  (w_idx),
        .o_issue     (w_issue),
        .o_cap_valid (w_cap_valid),
        .o_cap_idx   (w_cap_idx)
    );

    assign w_in[0]  = DATA_W'(in00);  assign out00 = g_slot[0].r_val;
    assign w_in[1]  = DATA_W'(in01);  assign out01 = g_slot[1].r_val;
    assign w_in[2]  = DATA_W'(in02);  assign out02 = g_slot[2].r_val;
    assign w_in[3]  = DATA_W'(in03);  assign out03 = g_slot[3].r_val;
    assign w_in[4]  = DATA_W'(in04);  assign out04 = g_slot[4].r_val;
    assign w_in[5]  = DATA_W'(in05);  assign out05 = g_slot[5].r_val;
    assign w_in[6]  = DATA_W'(in06);  assign out06 = g_slot[6].r_val;
    assign w_in[7]  = DATA_W'(in07);  assign out07 = g_slot[7].r_val;
    assign w_in[8]  = DATA_W'(in08);  assign out08 = g_slot[8].r_val;
    assign w_in[9]  = DATA_W'(in09);  assign out09 = g_slot[9].r_val;
    assign w_in[10] = DATA_W'(in10);  assign out10 = g_slot[10].r_val;
    assign w_in[11] = DATA_W'(in11);  assign out11 = g_slot[11].r_val;
    assign w_in[12] = DATA_W'(in12);  assign out12 = g_slot[12].r_val;
    assign w_in[13] = DATA_W'(in13);  assign out13 = g_slot[13].r_val;
    assign w_in[14] = DATA_W'(in14);  assign out14 = g_slot[14].r_val;
    assign w_in[15] = DATA_W'(in15);  assign out15 = g_slot[15].r_val;
    assign w_in[16] = DATA_W'(in16);  assign out16 = g_slot[16].r_val;
    assign w_in[17] = DATA_W'(in17);  assign out17 = g_slot[17].r_val;
    assign w_in[18] = DATA_W'(in18);  assign out18 = g_slot[18].r_val;
    assign w_in[19] = DATA_W'(in19);  assign out19 = g_slot[19].r_val;

    // Upper rddata bits may be unused when every read slot is narrower than 32.
    assign w_unused_rd = ^BRAM_rddata;

    for (genvar i = 0; i < MAX_REGS; i++) begin : g_slot
        logic [c_WIDTH[i]-1:0] r_val;

        assign w_wr_word[i] = c_IS_WRITE[i] ? w_in[i] : '0;

        if (c_IS_WRITE[i]) begin : g_wr
            always_ff @(posedge aclk or posedge areset) begin
                if (areset)
                    r_val <= '0;
                else if (w_issue && (w_idx == slot_idx_t'(i)))
                    r_val <= w_wr_word[i][c_WIDTH[i]-1:0];
            end
        end else begin : g_rd
            always_ff @(posedge aclk or posedge areset) begin
                if (areset)
                    r_val <= '0;
                else if (w_cap_valid && (w_cap_idx == slot_idx_t'(i)))
                    r_val <= BRAM_rddata[c_WIDTH[i]-1:0];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_bram_en     <= 1'b0;
            r_bram_we     <= WE_NONE;
            r_bram_addr   <= '0;
            r_bram_wrdata <= '0;
        end else if (w_issue) begin
            r_bram_en     <= 1'b1;
            r_bram_we     <= c_IS_WRITE[w_idx] ? WE_ALL : WE_NONE;
            r_bram_addr   <= BRAM_WIDTH'(slot_offset(w_idx));
            r_bram_wrdata <= w_wr_word[w_idx];
        end else begin
            r_bram_en     <= 1'b0;
            r_bram_we     <= WE_NONE;
        end
    end

    assign BRAM_en     = r_bram_en;
    assign BRAM_we     = r_bram_we;
    assign BRAM_addr   = r_bram_addr;
    assign BRAM_wrdata = r_bram_wrdata;
    assign BRAM_clk    = aclk;
    assign BRAM_rst    = areset;

endmodule
`default_nettype wire

// File: tb/tb_gpio_reg_array_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_reg_array_core
// Description : Directed self-checking bench for gpio_reg_array_core with a
//               one-cycle-latency BRAM model; stall expectations follow
//               GPIO_REG_ARRAY_BUSY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_reg_array_core;

    logic        aclk;
    logic        areset;
    logic [10:0] BRAM_addr;
    logic [31:0] BRAM_wrdata;
    logic [31:0] BRAM_rddata;
    logic        BRAM_en;
    logic [3:0]  BRAM_we;
    logic        BRAM_clk;
    logic        BRAM_rst;
    logic        BRAM_busy;

    logic [31:0] in00, in01, in02, in04, in05, in06, in07, in08, in09, in10;
    logic [31:0] in11, in12, in13, in14, in15, in16, in17, in18, in19;
    logic [7:0]  in03;
    logic [31:0] out00, out01, out02, out04, out05, out06, out07, out08, out09, out10;
    logic [31:0] out11, out12, out13, out14, out15, out16, out17, out18, out19;
    logic [7:0]  out03;

    logic [31:0] outs [20];
    logic [31:0] mem  [20];
    int          n_pass;
    int          n_total;
    int          cur;

    gpio_reg_array_core #(
        .NUM_REGS    (20),
        .BRAM_WIDTH  (11),
        .WIDTH_03    (8),
        .OUT00_INPUT (1),
        .OUT10_INPUT (1)
    ) dut (
        .aclk (aclk), .areset (areset),
        .BRAM_addr (BRAM_addr), .BRAM_wrdata (BRAM_wrdata), .BRAM_rddata (BRAM_rddata),
        .BRAM_en (BRAM_en), .BRAM_we (BRAM_we), .BRAM_clk (BRAM_clk), .BRAM_rst (BRAM_rst),
        .BRAM_busy (BRAM_busy),
        .in00 (in00), .in01 (in01), .in02 (in02), .in03 (in03), .in04 (in04),
        .in05 (in05), .in06 (in06), .in07 (in07), .in08 (in08), .in09 (in09),
        .in10 (in10), .in11 (in11), .in12 (in12), .in13 (in13), .in14 (in14),
        .in15 (in15), .in16 (in16), .in17 (in17), .in18 (in18), .in19 (in19),
        .out00 (out00), .out01 (out01), .out02 (out02), .out03 (out03), .out04 (out04),
        .out05 (out05), .out06 (out06), .out07 (out07), .out08 (out08), .out09 (out09),
        .out10 (out10), .out11 (out11), .out12 (out12), .out13 (out13), .out14 (out14),
        .out15 (out15), .out16 (out16), .out17 (out17), .out18 (out18), .out19 (out19)
    );

    assign outs[0]  = out00;  assign outs[1]  = out01;  assign outs[2]  = out02;
    assign outs[3]  = {24'h0, out03};
    assign outs[4]  = out04;  assign outs[5]  = out05;  assign outs[6]  = out06;
    assign outs[7]  = out07;  assign outs[8]  = out08;  assign outs[9]  = out09;
    assign outs[10] = out10;  assign outs[11] = out11;  assign outs[12] = out12;
    assign outs[13] = out13;  assign outs[14] = out14;  assign outs[15] = out15;
    assign outs[16] = out16;  assign outs[17] = out17;  assign outs[18] = out18;
    assign outs[19] = out19;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // BRAM port model: address seen in cycle C returns data during cycle C+1.
    initial begin
        logic rd;
        int   a;
        BRAM_rddata = 32'hDEAD_BEEF;
        forever begin
            @(negedge aclk);
            rd = BRAM_en && (BRAM_we == 4'h0);
            a  = int'(BRAM_addr) / 4;
            @(posedge aclk);
            #1;
            BRAM_rddata = (rd && a < 20) ? mem[a] : 32'hDEAD_BEEF;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 32'h%08h, want 32'h%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    function automatic logic [31:0] exp_rd(input int c);
        logic [31:0] m;
        m = mem[c];
        return (c == 3) ? {24'h0, m[7:0]} : m;
    endfunction

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 20; i++) mem[i] = {8'hA5, 8'(i), 8'h5A, 8'(i)};
        mem[1] = 32'h2222_2222;
        areset = 1'b1;
        BRAM_busy = 1'b0;
        in00 = 32'hFFFF_FFFF; in01 = '0; in02 = '0; in03 = '0; in04 = '0;
        in05 = '0; in06 = '0; in07 = '0; in08 = '0; in09 = '0;
        in10 = 32'h5555_5555; in11 = '0; in12 = '0; in13 = '0; in14 = '0;
        in15 = '0; in16 = '0; in17 = '0; in18 = '0; in19 = '0;

        repeat (3) step();
        chk("rst_en", 32'(BRAM_en), 32'h0);
        chk("rst_we", 32'(BRAM_we), 32'h0);
        chk("rst_addr", 32'(BRAM_addr), 32'h0);
        chk("rst_wrdata", BRAM_wrdata, 32'h0);
        chk("rst_out00", outs[0], 32'h0);
        chk("rst_out01", outs[1], 32'h0);
        chk("rst_out19", outs[19], 32'h0);

        areset = 1'b0;
        step();
        chk("s0_en", 32'(BRAM_en), 32'h1);
        chk("s0_addr", 32'(BRAM_addr), 32'h0);
        chk("s0_we", 32'(BRAM_we), 32'hF);
        chk("s0_wrdata", BRAM_wrdata, 32'hFFFF_FFFF);
        chk("s0_out00", outs[0], 32'hFFFF_FFFF);

        for (int s = 1; s < 20; s++) begin
            step();
            chk($sformatf("s%0d_en", s), 32'(BRAM_en), 32'h1);
            chk($sformatf("s%0d_addr", s), 32'(BRAM_addr), 32'(s * 4));
            chk($sformatf("s%0d_we", s), 32'(BRAM_we), (s == 10) ? 32'hF : 32'h0);
            if (s == 10) chk("s10_wrdata", BRAM_wrdata, 32'h5555_5555);
            if (s >= 2 && s - 2 != 0 && s - 2 != 10)
                chk($sformatf("cap_out%0d", s - 2), outs[s-2], exp_rd(s - 2));
            if (s == 12) begin
                chk("s12_out09_hold", outs[9], exp_rd(9));
                chk("s12_out11_idle", outs[11], 32'h0);
                chk("s12_out10_wr", outs[10], 32'h5555_5555);
            end
        end
        chk("cap_out01_val", outs[1], 32'h2222_2222);
        chk("cap_out03_narrow", outs[3], 32'h0000_0003);

        in00 = 32'h1234_5678;
        step();
        chk("wrap_addr", 32'(BRAM_addr), 32'h0);
        chk("wrap_we", 32'(BRAM_we), 32'hF);
        chk("wrap_wrdata", BRAM_wrdata, 32'h1234_5678);
        chk("wrap_out00", outs[0], 32'h1234_5678);
        chk("cap_out18", outs[18], exp_rd(18));
        step();
        chk("wrap_s1_addr", 32'(BRAM_addr), 32'h4);
        chk("cap_out19", outs[19], exp_rd(19));

        repeat (5) step();
        chk("pre_busy_addr", 32'(BRAM_addr), 32'h18);
        mem[6] = 32'h6666_0000;
        mem[7] = 32'h7777_0000;
        BRAM_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
`ifdef GPIO_REG_ARRAY_BUSY_EN
            chk($sformatf("busy%0d_en", k), 32'(BRAM_en), 32'h0);
            chk($sformatf("busy%0d_we", k), 32'(BRAM_we), 32'h0);
`else
            chk($sformatf("nobusy%0d_en", k), 32'(BRAM_en), 32'h1);
            chk($sformatf("nobusy%0d_addr", k), 32'(BRAM_addr), 32'((7 + k) * 4));
`endif
            if (k == 1) chk("busy_cap_out06", outs[6], 32'h6666_0000);
        end
        BRAM_busy = 1'b0;
        step();
`ifdef GPIO_REG_ARRAY_BUSY_EN
        chk("resume_en", 32'(BRAM_en), 32'h1);
        chk("resume_addr", 32'(BRAM_addr), 32'h1C);
        cur = 9;
`else
        chk("resume_addr", 32'(BRAM_addr), 32'h30);
        cur = 14;
`endif
        repeat (2) step();
        chk("resume_out07", outs[7], 32'h7777_0000);
        chk("hold_out19", outs[19], exp_rd(19));
        chk("pend_addr", 32'(BRAM_addr), 32'(cur * 4));

        areset = 1'b1;
        #2;
        chk("mid_rst_en", 32'(BRAM_en), 32'h0);
        chk("mid_rst_addr", 32'(BRAM_addr), 32'h0);
        chk("mid_rst_out00", outs[0], 32'h0);
        chk("mid_rst_out07", outs[7], 32'h0);
        areset = 1'b0;
        step();
        chk("post_rst_addr", 32'(BRAM_addr), 32'h0);
        chk("post_rst_we", 32'(BRAM_we), 32'hF);
        step();
        chk("post_rst_s1_addr", 32'(BRAM_addr), 32'h4);
        chk("post_rst_no_cap", outs[cur], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
